// File: rtl/clock_divider_pkg.sv
// Shared constants and helpers for the programmable clock divider.
// Holds the channel-count limit and the default parameter values used by the top and by each channel.
package clock_divider_pkg;

    localparam int MAX_CHANNEL_COUNT      = 16;
    localparam int DEFAULT_CHANNEL_COUNT  = 4;
    localparam int DEFAULT_DIVISOR_WIDTH  = 16;
    localparam int DEFAULT_DIVISOR_VALUE  = 2;

    typedef enum logic {
        MODE_STOPPED = 1'b0,
        MODE_RUNNING = 1'b1
    } channel_mode_t;

    // A single-channel divider still needs a 1-bit select port.
    function automatic int channel_select_width(input int channel_count);
        return (channel_count > 1) ? $clog2(channel_count) : 1;
    endfunction

endpackage

// File: rtl/divider_channel.sv
// One divider channel: free-running counter against the active divisor, a one-deep
// pending divisor slot, and registered output_clock / tick.
module divider_channel
    import clock_divider_pkg::*;
#(
    parameter int DIVISOR_WIDTH   = DEFAULT_DIVISOR_WIDTH,
    parameter int DEFAULT_DIVISOR = DEFAULT_DIVISOR_VALUE
) (
    input  logic                     input_clock,
    input  logic                     reset,
    input  logic                     enable,
    input  logic                     write_enable,
    input  logic [DIVISOR_WIDTH-1:0] write_divisor,
    output logic                     pending,
    output logic                     output_clock,
    output logic                     tick
);

    localparam logic [DIVISOR_WIDTH-1:0] ONE           = DIVISOR_WIDTH'(1);
    localparam logic [DIVISOR_WIDTH-1:0] RESET_DIVISOR = DIVISOR_WIDTH'(DEFAULT_DIVISOR);

    logic [DIVISOR_WIDTH-1:0] count;
    logic [DIVISOR_WIDTH-1:0] count_next;
    logic [DIVISOR_WIDTH-1:0] active_divisor;
    logic [DIVISOR_WIDTH-1:0] active_divisor_next;
    logic [DIVISOR_WIDTH-1:0] pending_divisor;
    logic [DIVISOR_WIDTH-1:0] pending_divisor_next;
    logic                     pending_next;
    logic                     output_clock_next;
    logic                     tick_next;
    logic [DIVISOR_WIDTH:0]   high_cycles;
    logic                     at_boundary;
    logic                     apply_pending;
    channel_mode_t            mode;

    // high_cycles is ceil(D/2), computed one bit wider so D at full scale cannot overflow.
    always_comb begin
        mode          = (enable && (active_divisor != '0)) ? MODE_RUNNING : MODE_STOPPED;
        high_cycles   = ({1'b0, active_divisor} + {{DIVISOR_WIDTH{1'b0}}, 1'b1}) >> 1;
        at_boundary   = (count == (active_divisor - ONE));
        apply_pending = pending && ((mode == MODE_STOPPED) || at_boundary);
    end

    always_comb begin
        count_next           = count;
        active_divisor_next  = active_divisor;
        pending_divisor_next = pending_divisor;
        pending_next         = pending;
        output_clock_next    = 1'b0;
        tick_next            = 1'b0;

        if (mode == MODE_RUNNING) begin
            output_clock_next = ({1'b0, count} < high_cycles);
            tick_next         = at_boundary;
            count_next        = at_boundary ? '0 : (count + ONE);
        end else begin
            count_next = '0;
        end

        if (apply_pending) begin
            active_divisor_next = pending_divisor;
            pending_next        = 1'b0;
        end

        // The top only issues a write while the slot is empty, so this never races apply_pending.
        if (write_enable) begin
            pending_divisor_next = write_divisor;
            pending_next         = 1'b1;
        end
    end

    always_ff @(posedge input_clock or posedge reset) begin
        if (reset) begin
            count           <= '0;
            active_divisor  <= RESET_DIVISOR;
            pending_divisor <= '0;
            pending         <= 1'b0;
            output_clock    <= 1'b0;
            tick            <= 1'b0;
        end else begin
            count           <= count_next;
            active_divisor  <= active_divisor_next;
            pending_divisor <= pending_divisor_next;
            pending         <= pending_next;
            output_clock    <= output_clock_next;
            tick            <= tick_next;
        end
    end

endmodule

// File: rtl/programmable_clock_divider.sv
// Multi-channel programmable clock divider: decodes divisor writes onto per-channel
// pending slots and reports back-pressure through divisor_ready.
module programmable_clock_divider
    import clock_divider_pkg::*;
#(
    parameter int CHANNEL_COUNT   = DEFAULT_CHANNEL_COUNT,
    parameter int DIVISOR_WIDTH   = DEFAULT_DIVISOR_WIDTH,
    parameter int DEFAULT_DIVISOR = DEFAULT_DIVISOR_VALUE,
    localparam int SELECT_WIDTH   = channel_select_width(CHANNEL_COUNT)
) (
    input  logic                     input_clock,
    input  logic                     reset,
    input  logic [CHANNEL_COUNT-1:0] enable,
    input  logic                     divisor_valid,
    input  logic [SELECT_WIDTH-1:0]  divisor_channel,
    input  logic [DIVISOR_WIDTH-1:0] divisor_in,
    output logic                     divisor_ready,
    output logic [CHANNEL_COUNT-1:0] output_clock,
    output logic [CHANNEL_COUNT-1:0] tick
);

    logic [CHANNEL_COUNT-1:0] pending_flags;
    logic [CHANNEL_COUNT-1:0] write_enable;

    // Out-of-range channels match no k, so such writes see ready high and are dropped.
    always_comb begin
        divisor_ready = 1'b1;
        for (int k = 0; k < CHANNEL_COUNT; k++) begin
            if ((int'(divisor_channel) == k) && pending_flags[k]) begin
                divisor_ready = 1'b0;
            end
        end
    end

    always_comb begin
        write_enable = '0;
        for (int k = 0; k < CHANNEL_COUNT; k++) begin
            write_enable[k] = divisor_valid && divisor_ready && (int'(divisor_channel) == k);
        end
    end

    for (genvar k = 0; k < CHANNEL_COUNT; k++) begin : g_channel
        divider_channel #(
            .DIVISOR_WIDTH   (DIVISOR_WIDTH),
            .DEFAULT_DIVISOR (DEFAULT_DIVISOR)
        ) u_channel (
            .input_clock   (input_clock),
            .reset         (reset),
            .enable        (enable[k]),
            .write_enable  (write_enable[k]),
            .write_divisor (divisor_in),
            .pending       (pending_flags[k]),
            .output_clock  (output_clock[k]),
            .tick          (tick[k])
        );
    end

endmodule

// File: tb/tb_programmable_clock_divider.sv
// Self-checking bench for programmable_clock_divider: directed table, corner-case
// sequences and randomized traffic checked against a period-level reference model.
module tb_programmable_clock_divider;

    localparam int N = 4;
    localparam int W = 16;

    logic           input_clock = 1'b0;
    logic           reset;
    logic [N-1:0]   enable;
    logic           divisor_valid;
    logic [1:0]     divisor_channel;
    logic [W-1:0]   divisor_in;
    logic           divisor_ready;
    logic [N-1:0]   output_clock;
    logic [N-1:0]   tick;

    logic [2:0]     enable3;
    logic           divisor_valid3;
    logic [1:0]     divisor_channel3;
    logic [W-1:0]   divisor_in3;
    logic           divisor_ready3;
    logic [2:0]     output_clock3;
    logic [2:0]     tick3;

    int             vectors = 0;
    int             miscompares = 0;
    logic           sampled_ready;

    int             m_d [N];
    int             m_c [N];
    int             m_pd [N];
    bit             m_pend [N];
    logic [N-1:0]   m_clk;
    logic [N-1:0]   m_tick;

    typedef struct {
        logic [N-1:0] en;
        logic         valid;
        logic [1:0]   ch;
        logic [W-1:0] din;
        logic [N-1:0] exp_clk;
        logic [N-1:0] exp_tick;
        logic         exp_ready;
    } vec_t;

    vec_t table_v [12];

    always #5 input_clock = ~input_clock;

    programmable_clock_divider #(
        .CHANNEL_COUNT   (N),
        .DIVISOR_WIDTH   (W),
        .DEFAULT_DIVISOR (2)
    ) dut (
        .input_clock     (input_clock),
        .reset           (reset),
        .enable          (enable),
        .divisor_valid   (divisor_valid),
        .divisor_channel (divisor_channel),
        .divisor_in      (divisor_in),
        .divisor_ready   (divisor_ready),
        .output_clock    (output_clock),
        .tick            (tick)
    );

    // Three channels leave select value 3 unused, which exercises the discard path.
    programmable_clock_divider #(
        .CHANNEL_COUNT   (3),
        .DIVISOR_WIDTH   (W),
        .DEFAULT_DIVISOR (2)
    ) dut3 (
        .input_clock     (input_clock),
        .reset           (reset),
        .enable          (enable3),
        .divisor_valid   (divisor_valid3),
        .divisor_channel (divisor_channel3),
        .divisor_in      (divisor_in3),
        .divisor_ready   (divisor_ready3),
        .output_clock    (output_clock3),
        .tick            (tick3)
    );

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s at %0t: actual=%h expected=%h", name, $time, actual, expected);
        end
    endtask

    function automatic bit model_ready(input int ch);
        return !((ch < N) && m_pend[ch]);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < N; k++) begin
            m_d[k]    = 2;
            m_c[k]    = 0;
            m_pd[k]   = 0;
            m_pend[k] = 1'b0;
        end
        m_clk  = '0;
        m_tick = '0;
    endtask

    // Period view: phase advances modulo D, first ceil(D/2) phases are high,
    // and a queued divisor is adopted whenever a period closes or the channel idles.
    task automatic model_edge(input bit accepted, input int wch, input int wdin);
        bit period_closed;
        for (int k = 0; k < N; k++) begin
            if (enable[k] && (m_d[k] != 0)) begin
                m_clk[k]      = (m_c[k] < (m_d[k] + 1) / 2);
                m_tick[k]     = (m_c[k] == m_d[k] - 1);
                period_closed = (m_c[k] == m_d[k] - 1);
                m_c[k]        = (m_c[k] + 1) % m_d[k];
            end else begin
                m_clk[k]      = 1'b0;
                m_tick[k]     = 1'b0;
                m_c[k]        = 0;
                period_closed = 1'b1;
            end
            if (period_closed && m_pend[k]) begin
                m_d[k]    = m_pd[k];
                m_pend[k] = 1'b0;
            end
        end
        if (accepted && (wch < N)) begin
            m_pd[wch]   = wdin;
            m_pend[wch] = 1'b1;
        end
    endtask

    task automatic step();
        bit acc;
        int ch;
        int din;
        @(negedge input_clock);
        sampled_ready = divisor_ready;
        ch  = int'(divisor_channel);
        din = int'(divisor_in);
        check("divisor_ready", divisor_ready, model_ready(ch));
        acc = divisor_valid && model_ready(ch);
        @(posedge input_clock);
        model_edge(acc, ch, din);
        #1;
        check("output_clock", output_clock, m_clk);
        check("tick", tick, m_tick);
    endtask

    task automatic do_reset();
        reset            = 1'b1;
        enable           = '0;
        divisor_valid    = 1'b0;
        divisor_channel  = '0;
        divisor_in       = '0;
        enable3          = '0;
        divisor_valid3   = 1'b0;
        divisor_channel3 = '0;
        divisor_in3      = '0;
        @(posedge input_clock);
        @(posedge input_clock);
        model_reset();
        #1;
        check("reset_clk", output_clock, 0);
        check("reset_tick", tick, 0);
        @(negedge input_clock);
        reset = 1'b0;
        @(posedge input_clock);
        model_edge(1'b0, 0, 0);
        #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit got;

        // D=2 on channel 0, then D=5 written mid-run takes over at the next boundary.
        table_v[0]  = '{4'b0001, 1'b0, 2'd0, 16'd0, 4'b0001, 4'b0000, 1'b1};
        table_v[1]  = '{4'b0001, 1'b0, 2'd0, 16'd0, 4'b0000, 4'b0001, 1'b1};
        table_v[2]  = '{4'b0001, 1'b0, 2'd0, 16'd0, 4'b0001, 4'b0000, 1'b1};
        table_v[3]  = '{4'b0001, 1'b1, 2'd0, 16'd5, 4'b0000, 4'b0001, 1'b1};
        table_v[4]  = '{4'b0001, 1'b0, 2'd0, 16'd0, 4'b0001, 4'b0000, 1'b0};
        table_v[5]  = '{4'b0001, 1'b0, 2'd0, 16'd0, 4'b0000, 4'b0001, 1'b0};
        table_v[6]  = '{4'b0001, 1'b0, 2'd0, 16'd0, 4'b0001, 4'b0000, 1'b1};
        table_v[7]  = '{4'b0001, 1'b0, 2'd0, 16'd0, 4'b0001, 4'b0000, 1'b1};
        table_v[8]  = '{4'b0001, 1'b0, 2'd0, 16'd0, 4'b0001, 4'b0000, 1'b1};
        table_v[9]  = '{4'b0001, 1'b0, 2'd0, 16'd0, 4'b0000, 4'b0000, 1'b1};
        table_v[10] = '{4'b0001, 1'b0, 2'd0, 16'd0, 4'b0000, 4'b0001, 1'b1};
        table_v[11] = '{4'b0001, 1'b0, 2'd0, 16'd0, 4'b0001, 4'b0000, 1'b1};

        do_reset();

        // Writes to an unpopulated channel are accepted and leave every channel untouched.
        enable3          = 3'b111;
        divisor_valid3   = 1'b1;
        divisor_channel3 = 2'd3;
        divisor_in3      = 16'd5;
        for (int i = 0; i < 8; i++) begin
            @(negedge input_clock);
            check("oob_ready", divisor_ready3, 1);
            @(posedge input_clock);
            #1;
            check("oob_clk", output_clock3, (i % 2 == 0) ? 3'b111 : 3'b000);
            check("oob_tick", tick3, (i % 2 == 0) ? 3'b000 : 3'b111);
        end

        do_reset();
        for (int i = 0; i < 12; i++) begin
            enable          = table_v[i].en;
            divisor_valid   = table_v[i].valid;
            divisor_channel = table_v[i].ch;
            divisor_in      = table_v[i].din;
            step();
            check("tbl_ready", sampled_ready, table_v[i].exp_ready);
            check("tbl_clk", output_clock, table_v[i].exp_clk);
            check("tbl_tick", tick, table_v[i].exp_tick);
        end
        divisor_valid = 1'b0;

        // A second write to a channel with a queued divisor is held off until the first lands.
        do_reset();
        enable = 4'b0010;
        step();
        divisor_valid   = 1'b1;
        divisor_channel = 2'd1;
        divisor_in      = 16'd7;
        step();
        divisor_in = 16'd9;
        step();
        check("second_write_blocked", sampled_ready, 0);
        got = sampled_ready;
        for (int i = 0; (i < 20) && !got; i++) begin
            step();
            got = sampled_ready;
        end
        check("second_write_accepted", got, 1);
        divisor_valid = 1'b0;
        repeat (20) step();

        // Stop channel 0 with D=0, then restart it with D=3.
        enable          = 4'b1111;
        divisor_valid   = 1'b1;
        divisor_channel = 2'd0;
        divisor_in      = 16'd0;
        step();
        divisor_valid = 1'b0;
        repeat (6) step();
        check("stopped_clk", output_clock[0], 0);
        check("stopped_tick", tick[0], 0);
        divisor_valid = 1'b1;
        divisor_in    = 16'd3;
        step();
        divisor_valid = 1'b0;
        step();
        step();
        check("restart_high", output_clock[0], 1);

        // Reset lands mid-period while channel 2 holds a queued divisor.
        divisor_valid   = 1'b1;
        divisor_channel = 2'd2;
        divisor_in      = 16'd6;
        step();
        divisor_valid = 1'b0;
        check("pre_reset_active", output_clock[0], 1);
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_clk", output_clock, 0);
        check("async_reset_tick", tick, 0);
        check("reset_ready_ch2", divisor_ready, 1);
        do_reset();
        enable = 4'b0100;
        step();
        check("post_reset_clk", output_clock[2], 1);
        step();
        check("post_reset_tick", tick[2], 1);
        repeat (4) step();

        // Randomized traffic against the reference model.
        do_reset();
        enable = 4'b1111;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 15) == 0) begin
                enable = N'($urandom);
            end
            divisor_valid   = ($urandom_range(0, 2) == 0);
            divisor_channel = 2'($urandom_range(0, 3));
            divisor_in      = W'($urandom_range(0, 7));
            step();
        end
        divisor_valid = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
